// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and issues one-outstanding reads to imem.
// Optional `FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk_40,
  input  logic        Rst_40,
  input  logic        Stall_40,
  input  logic        Redirect_40,
  input  logic [31:0] RedirectTarget_40,
  output logic        imem_req_40,
  output logic [31:0] imem_addr_40,
  input  logic        imem_ack_40,
  input  logic [31:0] imem_rdata_40,
  output logic [31:0] instruction_out_40,
  output logic [31:0] PCNow_out_40,
  output logic [31:0] PCNext4_out_40,
  output logic        Write_out_40,
`ifdef FETCH_PERF_CNT_EN
  output logic        Flush_out_40,
  output logic [31:0] FetchCount_out_40,
  output logic [31:0] StallCount_out_40
`else
  output logic        Flush_out_40
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        ack_valid;
  logic        emit;
  logic [31:0] emit_data;

  assign target    = {RedirectTarget_40[31:2], 2'b00};
  assign pc_plus4  = pc + 32'd4;
  assign ack_valid = imem_req_40 && imem_ack_40;

  // An instruction reaches IF/ID either straight from memory or from the holding buffer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    emit      = 1'b0;
    emit_data = imem_rdata_40;
    if (!Redirect_40 && !Stall_40) begin
      if (state == FETCH && ack_valid) begin
        emit = 1'b1;
      end else if (state == HOLD) begin
        emit      = 1'b1;
        emit_data = hold_buf;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk_40 or posedge Rst_40) begin
    if (Rst_40) begin
      state              <= FETCH;
      pc                 <= RESET_PC;
      hold_buf           <= '0;
      imem_req_40        <= 1'b0;
      imem_addr_40       <= RESET_PC;
      instruction_out_40 <= '0;
      PCNow_out_40       <= '0;
      PCNext4_out_40     <= '0;
      Write_out_40       <= 1'b0;
      Flush_out_40       <= 1'b0;
    end else begin
      Write_out_40 <= emit;
      Flush_out_40 <= Redirect_40;
      if (emit) begin
        instruction_out_40 <= emit_data;
        PCNow_out_40       <= pc;
        PCNext4_out_40     <= pc_plus4;
        pc                 <= pc_plus4;
        imem_addr_40       <= pc_plus4;
      end
      unique case (state)
        FETCH: begin
          if (!imem_req_40) begin
            imem_req_40 <= 1'b1;
            if (Redirect_40) begin
              pc           <= target;
              imem_addr_40 <= target;
            end
          end else if (Redirect_40) begin
            pc <= target;
            // A returning ack lets the new address go out at once; otherwise wait it out.
            if (imem_ack_40) imem_addr_40 <= target;
            else             state        <= DROP;
          end else if (imem_ack_40 && Stall_40) begin
            hold_buf    <= imem_rdata_40;
            imem_req_40 <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (Redirect_40) begin
            pc           <= target;
            imem_addr_40 <= target;
            imem_req_40  <= 1'b1;
            state        <= FETCH;
          end else if (!Stall_40) begin
            imem_req_40 <= 1'b1;
            state       <= FETCH;
          end
        end
        DROP: begin
          if (Redirect_40) pc <= target;
          if (ack_valid) begin
            imem_addr_40 <= Redirect_40 ? target : pc;
            state        <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk_40 or posedge Rst_40) begin
    if (Rst_40) begin
      FetchCount_out_40 <= '0;
      StallCount_out_40 <= '0;
    end else begin
      if (emit) FetchCount_out_40 <= FetchCount_out_40 + 32'd1;
      if (state == HOLD || (state == FETCH && imem_req_40 && !imem_ack_40))
        StallCount_out_40 <= StallCount_out_40 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage (main instance plus a RESET_PC wrap instance).
module tb_if_fetch_stage;

  logic        Clk_40 = 1'b0;
  logic        Rst_40 = 1'b1;
  logic        Stall_40 = 1'b0;
  logic        Redirect_40 = 1'b0;
  logic [31:0] RedirectTarget_40 = '0;
  logic        imem_req_40;
  logic [31:0] imem_addr_40;
  logic        imem_ack_40;
  logic [31:0] imem_rdata_40;
  logic [31:0] instruction_out_40, PCNow_out_40, PCNext4_out_40;
  logic        Write_out_40, Flush_out_40;

  logic        req2, ack2, write2, flush2;
  logic [31:0] addr2, rdata2, instr2, pcnow2, pcnext2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt1, stall_cnt1, fetch_cnt2, stall_cnt2;
`endif

  logic [1:0] lat = 2'd0;
  logic [1:0] wcnt;
  logic       ack_force = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 Clk_40 = ~Clk_40;

  // Memory model: ack after `lat` waiting cycles; address 0x10 holds a known load word.
  assign imem_ack_40   = (imem_req_40 && wcnt == lat) || ack_force;
  assign imem_rdata_40 = (imem_addr_40 == 32'h10) ? 32'h8C22_0004 : imem_addr_40 ^ 32'hA5A5_0000;
  always @(posedge Clk_40 or posedge Rst_40) begin
    if (Rst_40)                          wcnt <= 2'd0;
    else if (imem_req_40 && !imem_ack_40) wcnt <= wcnt + 2'd1;
    else                                 wcnt <= 2'd0;
  end

  assign ack2   = req2;
  assign rdata2 = addr2 ^ 32'hA5A5_0000;

  if_fetch_stage dut (
    .Clk_40(Clk_40), .Rst_40(Rst_40), .Stall_40(Stall_40), .Redirect_40(Redirect_40),
    .RedirectTarget_40(RedirectTarget_40), .imem_req_40(imem_req_40), .imem_addr_40(imem_addr_40),
    .imem_ack_40(imem_ack_40), .imem_rdata_40(imem_rdata_40),
    .instruction_out_40(instruction_out_40), .PCNow_out_40(PCNow_out_40),
    .PCNext4_out_40(PCNext4_out_40), .Write_out_40(Write_out_40),
`ifdef FETCH_PERF_CNT_EN
    .FetchCount_out_40(fetch_cnt1), .StallCount_out_40(stall_cnt1),
`endif
    .Flush_out_40(Flush_out_40)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk_40(Clk_40), .Rst_40(Rst_40), .Stall_40(1'b0), .Redirect_40(1'b0),
    .RedirectTarget_40(32'h0), .imem_req_40(req2), .imem_addr_40(addr2),
    .imem_ack_40(ack2), .imem_rdata_40(rdata2),
    .instruction_out_40(instr2), .PCNow_out_40(pcnow2),
    .PCNext4_out_40(pcnext2), .Write_out_40(write2),
`ifdef FETCH_PERF_CNT_EN
    .FetchCount_out_40(fetch_cnt2), .StallCount_out_40(stall_cnt2),
`endif
    .Flush_out_40(flush2)
  );

  task automatic step();
    @(negedge Clk_40);
  endtask

  task automatic do_reset(input logic [1:0] l);
    Rst_40 = 1'b1; Stall_40 = 1'b0; Redirect_40 = 1'b0;
    RedirectTarget_40 = '0; ack_force = 1'b0; lat = l;
    step(); step();
    Rst_40 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'd0);
    Rst_40 = 1'b1;
    #1;
    checks++; if (imem_req_40 !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req_40); end
    checks++; if (Write_out_40 !== 1'b0 || Flush_out_40 !== 1'b0) begin errors++; $display("FAIL reset_strobes: got w=%b f=%b want 0 0", Write_out_40, Flush_out_40); end
    checks++; if ({instruction_out_40, PCNow_out_40, PCNext4_out_40} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h %h %h want zeros", instruction_out_40, PCNow_out_40, PCNext4_out_40); end
    step();
    Rst_40 = 1'b0;
    step();
    checks++; if (imem_req_40 !== 1'b1 || imem_addr_40 !== 32'h0) begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1 00000000", imem_req_40, imem_addr_40); end
  endtask

  task automatic test_zero_wait();
    do_reset(2'd0);
    step();
    checks++; if (Write_out_40 !== 1'b0) begin errors++; $display("FAIL zw_first_write: got %b want 0", Write_out_40); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (Write_out_40 !== 1'b1 || PCNow_out_40 !== 32'(4 * i) || PCNext4_out_40 !== 32'(4 * i + 4)
          || instruction_out_40 !== (32'(4 * i) ^ 32'hA5A5_0000)) begin
        errors++;
        $display("FAIL zw_write%0d: got w=%b pc=%h n4=%h ins=%h want 1 %h %h %h", i, Write_out_40,
                 PCNow_out_40, PCNext4_out_40, instruction_out_40, 32'(4 * i), 32'(4 * i + 4),
                 32'(4 * i) ^ 32'hA5A5_0000);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_cnt1 !== 32'd4) begin errors++; $display("FAIL zw_fetch_cnt: got %0d want 4", fetch_cnt1); end
`endif
  endtask

  task automatic test_latency();
    do_reset(2'd2);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        checks++;
        if (imem_req_40 !== 1'b1 || imem_addr_40 !== 32'(4 * k)
            || Write_out_40 !== (j == 0 && k != 0)) begin
          errors++;
          $display("FAIL lat_k%0d_j%0d: got req=%b addr=%h w=%b want 1 %h %b", k, j, imem_req_40,
                   imem_addr_40, Write_out_40, 32'(4 * k), (j == 0 && k != 0));
        end
        if (j == 0 && k != 0) begin
          checks++; if (PCNow_out_40 !== 32'(4 * (k - 1))) begin errors++; $display("FAIL lat_pcnow%0d: got %h want %h", k, PCNow_out_40, 32'(4 * (k - 1))); end
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset(2'd0);
    for (int i = 0; i < 5; i++) step();
    checks++; if (imem_addr_40 !== 32'h10 || imem_ack_40 !== 1'b1) begin errors++; $display("FAIL st_setup: got addr=%h ack=%b want 00000010 1", imem_addr_40, imem_ack_40); end
    Stall_40 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req_40 !== 1'b0 || Write_out_40 !== 1'b0) begin errors++; $display("FAIL st_hold%0d: got req=%b w=%b want 0 0", i, imem_req_40, Write_out_40); end
    end
    Stall_40 = 1'b0;
    step();
    checks++;
    if (Write_out_40 !== 1'b1 || instruction_out_40 !== 32'h8C22_0004 || PCNow_out_40 !== 32'h10
        || PCNext4_out_40 !== 32'h14) begin
      errors++;
      $display("FAIL st_release: got w=%b ins=%h pc=%h n4=%h want 1 8c220004 00000010 00000014",
               Write_out_40, instruction_out_40, PCNow_out_40, PCNext4_out_40);
    end
    checks++; if (imem_req_40 !== 1'b1 || imem_addr_40 !== 32'h14) begin errors++; $display("FAIL st_next_fetch: got req=%b addr=%h want 1 00000014", imem_req_40, imem_addr_40); end
  endtask

  task automatic test_redirect_outstanding();
    do_reset(2'd2);
    step();
    Redirect_40 = 1'b1; RedirectTarget_40 = 32'h0000_0103;
    step();
    Redirect_40 = 1'b0;
    checks++; if (Flush_out_40 !== 1'b1 || Write_out_40 !== 1'b0) begin errors++; $display("FAIL rd_flush: got f=%b w=%b want 1 0", Flush_out_40, Write_out_40); end
    checks++; if (imem_req_40 !== 1'b1 || imem_addr_40 !== 32'h0) begin errors++; $display("FAIL rd_stale: got req=%b addr=%h want 1 00000000", imem_req_40, imem_addr_40); end
    step();
    checks++; if (Flush_out_40 !== 1'b0 || imem_ack_40 !== 1'b1) begin errors++; $display("FAIL rd_flush_once: got f=%b ack=%b want 0 1", Flush_out_40, imem_ack_40); end
    step();
    checks++; if (Write_out_40 !== 1'b0 || imem_addr_40 !== 32'h100) begin errors++; $display("FAIL rd_drop: got w=%b addr=%h want 0 00000100", Write_out_40, imem_addr_40); end
    step(); step(); step();
    checks++; if (Write_out_40 !== 1'b1 || PCNow_out_40 !== 32'h100 || instruction_out_40 !== 32'hA5A5_0100) begin errors++; $display("FAIL rd_target_write: got w=%b pc=%h ins=%h want 1 00000100 a5a50100", Write_out_40, PCNow_out_40, instruction_out_40); end
  endtask

  task automatic test_redirect_hold();
    do_reset(2'd0);
    step();
    Stall_40 = 1'b1;
    step();
    checks++; if (imem_req_40 !== 1'b0) begin errors++; $display("FAIL rh_hold: got req=%b want 0", imem_req_40); end
    Redirect_40 = 1'b1; RedirectTarget_40 = 32'h0000_0200;
    step();
    Redirect_40 = 1'b0; Stall_40 = 1'b0;
    checks++; if (Flush_out_40 !== 1'b1 || Write_out_40 !== 1'b0) begin errors++; $display("FAIL rh_flush: got f=%b w=%b want 1 0", Flush_out_40, Write_out_40); end
    checks++; if (imem_req_40 !== 1'b1 || imem_addr_40 !== 32'h200) begin errors++; $display("FAIL rh_target: got req=%b addr=%h want 1 00000200", imem_req_40, imem_addr_40); end
    step();
    checks++; if (Write_out_40 !== 1'b1 || PCNow_out_40 !== 32'h200 || Flush_out_40 !== 1'b0) begin errors++; $display("FAIL rh_write: got w=%b pc=%h f=%b want 1 00000200 0", Write_out_40, PCNow_out_40, Flush_out_40); end
  endtask

  task automatic test_back_to_back();
    do_reset(2'd0);
    step(); step();
    Redirect_40 = 1'b1; RedirectTarget_40 = 32'h0000_0306;
    step();
    Redirect_40 = 1'b0;
    checks++; if (Flush_out_40 !== 1'b1 || Write_out_40 !== 1'b0 || imem_addr_40 !== 32'h304) begin errors++; $display("FAIL bb_redirect: got f=%b w=%b addr=%h want 1 0 00000304", Flush_out_40, Write_out_40, imem_addr_40); end
    step();
    checks++; if (Write_out_40 !== 1'b1 || PCNow_out_40 !== 32'h304 || PCNext4_out_40 !== 32'h308) begin errors++; $display("FAIL bb_write: got w=%b pc=%h n4=%h want 1 00000304 00000308", Write_out_40, PCNow_out_40, PCNext4_out_40); end
  endtask

  task automatic test_reset_mid_request();
    do_reset(2'd2);
    step();
    Rst_40 = 1'b1;
    #1;
    checks++; if (imem_req_40 !== 1'b0) begin errors++; $display("FAIL rm_req_drop: got %b want 0", imem_req_40); end
    ack_force = 1'b1;
    step();
    Rst_40 = 1'b0;
    step();
    ack_force = 1'b0;
    checks++; if (Write_out_40 !== 1'b0 || imem_req_40 !== 1'b1 || imem_addr_40 !== 32'h0) begin errors++; $display("FAIL rm_late_ack: got w=%b req=%b addr=%h want 0 1 00000000", Write_out_40, imem_req_40, imem_addr_40); end
  endtask

  task automatic test_wrap();
    do_reset(2'd0);
    step();
    checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_first_req: got req=%b addr=%h want 1 fffffffc", req2, addr2); end
    step();
    checks++; if (write2 !== 1'b1 || pcnow2 !== 32'hFFFF_FFFC || pcnext2 !== 32'h0 || instr2 !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wr_first_write: got w=%b pc=%h n4=%h ins=%h want 1 fffffffc 00000000 5a5afffc", write2, pcnow2, pcnext2, instr2); end
    checks++; if (addr2 !== 32'h0) begin errors++; $display("FAIL wr_second_addr: got %h want 00000000", addr2); end
    step();
    checks++; if (write2 !== 1'b1 || pcnow2 !== 32'h0 || pcnext2 !== 32'h4) begin errors++; $display("FAIL wr_second_write: got w=%b pc=%h n4=%h want 1 00000000 00000004", write2, pcnow2, pcnext2); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_cnt2 !== 32'd2) begin errors++; $display("FAIL wr_fetch_cnt: got %0d want 2", fetch_cnt2); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_outstanding();
    test_redirect_hold();
    test_back_to_back();
    test_reset_mid_request();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
